// File: rtl/cpu_pkg.sv
// Shared datapath definitions: immediate-format select codes and default widths.
package cpu_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT = 1;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_BAD = 3'b111;

endpackage

// File: rtl/imm_pipe_slice.sv
// One elastic pipeline slice: a valid bit plus the decoded immediate beat it carries.
module imm_pipe_slice
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            next_valid,
  input  logic [XLEN-1:0] next_imm,
  input  logic [2:0]      next_sel,
  input  logic            next_err,
  output logic            valid,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      sel,
  output logic            err
);

  // NOTE: state registers use non-blocking assignments so every slice samples
  // its upstream neighbour's pre-edge value and beats shift by exactly one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= next_valid;
    end
  end

  // NOTE: the data registers are reset as well, because the output must read
  // zero during reset; flush only kills the valid bit and leaves data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm <= '0;
      sel <= IMM_I;
      err <= 1'b0;
    end else if (load) begin
      imm <= next_imm;
      sel <= next_sel;
      err <= next_err;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic immediate generator: decodes every RISC-V immediate format at the input
// and carries the extended result through DEPTH valid/ready slices.
module imm_gen_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      out_sel,
  output logic            out_err
);

  // Signed operands are widened by the size cast, which replicates inst[31].
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] word,
                                                 input logic [2:0]  sel);
    logic [XLEN-1:0] value;
    value = '0;
    case (sel)
      IMM_I:   value = XLEN'($signed(word[31:20]));
      IMM_S:   value = XLEN'($signed({word[31:25], word[11:7]}));
      IMM_B:   value = XLEN'($signed({word[31], word[7], word[30:25], word[11:8], 1'b0}));
      IMM_U:   value = XLEN'($signed({word[31:12], 12'b0}));
      IMM_J:   value = XLEN'($signed({word[31], word[19:12], word[20], word[30:21], 1'b0}));
      IMM_Z:   value = XLEN'(word[19:15]);
      IMM_SH:  value = (XLEN == 64) ? XLEN'(word[25:20]) : XLEN'(word[24:20]);
      default: value = '0;
    endcase
    return value;
  endfunction

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic            unused_opcode;

  assign dec_imm       = decode_imm(inst, imm_sel);
  assign dec_err       = (imm_sel == IMM_BAD);
  assign unused_opcode = ^inst[6:0];

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [2:0]       sel_q [DEPTH];

  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] src_err;
  logic [XLEN-1:0]  src_imm [DEPTH];
  logic [2:0]       src_sel [DEPTH];

  logic [DEPTH:0]   ready;

  // NOTE: ready starts from a full default so no path through the loop can
  // leave a bit unassigned and infer a latch.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = !valid_q[i] || ready[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    if (g == 0) begin : g_head
      assign src_valid[g] = in_valid;
      assign src_imm[g]   = dec_imm;
      assign src_sel[g]   = imm_sel;
      assign src_err[g]   = dec_err;
    end else begin : g_link
      assign src_valid[g] = valid_q[g-1];
      assign src_imm[g]   = imm_q[g-1];
      assign src_sel[g]   = sel_q[g-1];
      assign src_err[g]   = err_q[g-1];
    end

    imm_pipe_slice #(
      .XLEN (XLEN)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (ready[g]),
      .next_valid (src_valid[g]),
      .next_imm   (src_imm[g]),
      .next_sel   (src_sel[g]),
      .next_err   (src_err[g]),
      .valid      (valid_q[g]),
      .imm        (imm_q[g]),
      .sel        (sel_q[g]),
      .err        (err_q[g])
    );
  end

  // Flush wins over acceptance so the beat presented alongside it is dropped.
  assign in_ready  = ready[0] && !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign imm       = imm_q[DEPTH-1];
  assign out_sel   = sel_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table, scoreboard and corner-case sequences.
module tb_imm_gen_pipe;
  import cpu_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [2:0]      imm_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      out_sel;
  logic            out_err;

  logic            s_flush;
  logic            s_in_valid;
  logic            s_in_ready;
  logic            s_out_valid;
  logic            s_out_ready;
  logic [31:0]     s_imm;
  logic [2:0]      s_out_sel;
  logic            s_out_err;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .out_sel(out_sel), .out_err(out_err)
  );

  imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .inst(inst), .imm_sel(imm_sel), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .imm(s_imm), .out_sel(s_out_sel), .out_err(s_out_err)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [63:0] exp64;
    logic [31:0] exp32;
    logic        err;
  } vec_t;

  vec_t tbl [16];
  exp_t sb [$];
  exp_t cur_exp;
  exp_t mon_e;
  int   n_cmp;
  int   n_err;
  int   n_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode built from bit fields and explicit sign masks.
  function automatic logic [63:0] model(input logic [31:0] w, input logic [2:0] s);
    logic [63:0] v;
    v = 64'd0;
    case (s)
      IMM_I:  begin v = 64'(w[31:20]);                        if (w[31]) v = v | ~64'hFFF;       end
      IMM_S:  begin v = 64'({w[31:25], w[11:7]});             if (w[31]) v = v | ~64'hFFF;       end
      IMM_B:  begin v = 64'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) v = v | ~64'h1FFF; end
      IMM_U:  begin v = 64'({w[31:12], 12'h000});             if (w[31]) v = v | ~64'hFFFF_FFFF; end
      IMM_J:  begin v = 64'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) v = v | ~64'h1F_FFFF; end
      IMM_Z:  v = 64'(w[19:15]);
      IMM_SH: v = 64'(w[25:20]);
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s);
    in_valid = v;
    inst     = w;
    imm_sel  = s;
    cur_exp  = '{model(w, s), s, (s == 3'b111)};
  endtask

  // Scoreboard: accepted beats are pushed, consumed beats are popped and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("out_imm", 64'(imm), mon_e.imm);
          check("out_sel", 64'(out_sel), 64'(mon_e.sel));
          check("out_err", 64'(out_err), 64'(mon_e.err));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        n_push++;
      end
    end
  end

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);
  endtask

  task automatic latency_check(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'h00300113, IMM_I);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("%s_lat_cycle%0d", tag, k), 64'(out_valid), 64'(k == DEPTH - 1));
      if (k != DEPTH - 1) begin @(posedge clk); #1; end
    end
    check($sformatf("%s_lat_imm", tag), 64'(imm), 64'd3);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int start;
    int cyc;
    logic [63:0] snap_imm;
    logic [2:0]  snap_sel;

    n_cmp = 0; n_err = 0; n_push = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'd0; imm_sel = 3'd0; cur_exp = '{64'd0, 3'd0, 1'b0};
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;

    tbl[0]  = '{32'h00300113, IMM_I,   64'd3,                   32'd3,         1'b0};
    tbl[1]  = '{32'h001120A3, IMM_S,   64'd1,                   32'd1,         1'b0};
    tbl[2]  = '{32'h00628263, IMM_B,   64'd4,                   32'd4,         1'b0};
    tbl[3]  = '{32'h00001137, IMM_U,   64'h1000,                32'h1000,      1'b0};
    tbl[4]  = '{32'h004000EF, IMM_J,   64'd4,                   32'd4,         1'b0};
    tbl[5]  = '{32'hFFF00093, IMM_I,   64'hFFFFFFFFFFFFFFFF,    32'hFFFFFFFF,  1'b0};
    tbl[6]  = '{32'h800000B7, IMM_U,   64'hFFFFFFFF80000000,    32'h80000000,  1'b0};
    tbl[7]  = '{32'h3002D0F3, IMM_Z,   64'd5,                   32'd5,         1'b0};
    tbl[8]  = '{32'h02500093, IMM_SH,  64'h25,                  32'h5,         1'b0};
    tbl[9]  = '{32'hFE112E23, IMM_S,   64'hFFFFFFFFFFFFFFFC,    32'hFFFFFFFC,  1'b0};
    tbl[10] = '{32'hFE000EE3, IMM_B,   64'hFFFFFFFFFFFFFFFC,    32'hFFFFFFFC,  1'b0};
    tbl[11] = '{32'hFFDFF0EF, IMM_J,   64'hFFFFFFFFFFFFFFFC,    32'hFFFFFFFC,  1'b0};
    tbl[12] = '{32'hFFFFFFFF, IMM_Z,   64'h1F,                  32'h1F,        1'b0};
    tbl[13] = '{32'hFFFFFFFF, IMM_SH,  64'h3F,                  32'h1F,        1'b0};
    tbl[14] = '{32'hFFFFFFFF, IMM_BAD, 64'd0,                   32'd0,         1'b1};
    tbl[15] = '{32'h7FFFF037, IMM_U,   64'h7FFFF000,            32'h7FFFF000,  1'b0};

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_s_out_valid", 64'(s_out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_blocks_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b0;

    latency_check("first");

    // Table-driven streaming: main DUT via scoreboard, 32-bit DEPTH=1 DUT directly
    @(posedge clk); #1;
    out_ready  = 1'b1;
    s_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      inst     = tbl[i].inst;
      imm_sel  = tbl[i].sel;
      cur_exp  = '{tbl[i].exp64, tbl[i].sel, tbl[i].err};
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_s_valid", i), 64'(s_out_valid), 64'd1);
      check($sformatf("tbl%0d_s_imm", i), 64'(s_imm), 64'(tbl[i].exp32));
      check($sformatf("tbl%0d_s_sel", i), 64'(s_out_sel), 64'(tbl[i].sel));
      check($sformatf("tbl%0d_s_err", i), 64'(s_out_err), 64'(tbl[i].err));
    end
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    drain();

    // Backpressure: fill, hold, push+pop while full, then drain in order
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 6)));
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(DEPTH));
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    snap_imm = imm;
    snap_sel = out_sel;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_imm", 64'(imm), snap_imm);
      check("bp_hold_sel", 64'(out_sel), 64'(snap_sel));
    end
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)));
    out_ready = 1'b1;
    #1;
    check("bp_pushpop_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("bp_still_full", 64'(in_ready), 64'd0);
    drain();

    // Flush with the pipeline full and a beat presented
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 6)));
      @(posedge clk); #1;
    end
    drive(1'b1, 32'h00300113, IMM_I);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_valid_before", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid_after", 64'(out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("flush_stays_empty", 64'(out_valid), 64'd0);
    end
    check("flush_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a stream
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 6)));
      @(posedge clk); #1;
    end
    check("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_imm", 64'(imm), 64'd0);
    check("rst_mid_out_sel", 64'(out_sel), 64'd0);
    check("rst_mid_out_err", 64'(out_err), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    latency_check("post_rst");

    // Random traffic against the reference model
    start = n_push;
    cyc   = 0;
    while (n_push < start + 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      cyc++;
    end
    flush = 1'b0;
    check("rand_push_count", 64'(n_push - start), 64'd10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, elastic immediate-generation stage for the RV32/RV64 datapath. It decodes the immediate for every RISC-V format plus CSR-zimm and shift-amount forms, sign/zero-extends to XLEN, and carries the result through DEPTH registered slices with valid/ready handshakes and a pipeline flush. It sits between the fetch/decode boundary and the execute-stage operand muxes, and replaces the single-cycle combinational immediate generator.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- DEPTH, 1: number of registered slices; legal values 1 to 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kills every in-flight beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  slice 0 can accept this cycle.
- inst  in  32  raw instruction word.
- imm_sel  in  3  format select (encoding below).
- out_valid  out  1  last slice holds a beat.
- out_ready  in  1  consumer accepts.
- imm  out  XLEN  extended immediate.
- out_sel  out  3  imm_sel carried with the beat.
- out_err  out  1  beat used an illegal imm_sel.

## Operation
- imm_sel encoding and result:
  - 000 I: sext(inst[31:20]).
  - 001 S: sext({inst[31:25], inst[11:7]}).
  - 010 B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 011 U: sext({inst[31:12], 12'b0}).
  - 100 J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 101 Z: zext(inst[19:15]) (CSR zimm).
  - 110 SH: zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
  - 111: imm=0, out_err=1.
- sext replicates inst[31] up to bit XLEN-1. U-type on XLEN=64 is sign-extended from bit 31.
- Decode is combinational at the input. Each slice stores {valid, imm, sel, err}.
- Slice i ready: !valid[i] || ready[i+1], where ready[DEPTH] = out_ready. in_ready = ready[0] && !flush.
- Slice i loads from i-1 when ready[i]. valid[i] takes valid[i-1], or in_valid for slice 0.
- Data registers hold their value when not loading. No bubbles: throughput is 1 beat/cycle when out_ready stays high.
- flush: all valid bits clear on the next edge. The input beat presented in the same cycle is not accepted (in_ready=0). Data registers are not cleared.
- Output hold: while out_valid && !out_ready, imm/out_sel/out_err are stable.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. visible for the cycle following edge N+DEPTH-1. With DEPTH=1 it is visible the cycle after acceptance.
- Reset (async assert, state held while rst_n=0):
  - all valid=0, imm=0, out_sel=000, out_err=0.
  - in_ready=1 once rst_n deasserts, unless flush is high.
- Reset mid-operation discards all beats immediately and asynchronously. out_valid falls without waiting for a clock edge.
- Full: with DEPTH beats held and out_ready=0, in_ready=0.
- Simultaneous pop and push when full: allowed in the same cycle; occupancy is unchanged.
- flush and out_ready in the same cycle: the consumer may sample the current output beat; it is still cleared at the edge.
- in_ready, the ready chain and out_valid have no combinational path from in_valid. in_ready depends combinationally on out_ready and flush.

## Structure
- Shared package cpu_pkg holds:
  - IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH localparams (3-bit).
  - XLEN default.
- Sub-module imm_pipe_slice: one valid/data register with a load/flush interface, instantiated DEPTH times by generate.
- Decode logic is a function inside imm_gen_pipe.

## Test plan
- XLEN=32, DEPTH=1, streaming with out_ready=1:
  - 0x00300113/I → 3.
  - 0x001120A3/S → 1.
  - 0x00628263/B → 4.
  - 0x00001137/U → 0x00001000.
  - 0x004000EF/J → 4.
  - Each beat appears one cycle after acceptance, with no gaps.
- Sign and extension:
  - XLEN=64: 0xFFF00093/I → 0xFFFFFFFFFFFFFFFF.
  - XLEN=64: 0x800000B7/U → 0xFFFFFFFF80000000.
  - 0x3002D0F3/Z → 5.
  - imm_sel=111 → imm=0, out_err=1.
- Backpressure, DEPTH=2, out_ready=0: push 3 beats; in_ready drops after 2 are accepted and the output holds steady. Release out_ready: beats drain in order with no loss or duplication.
- Flush, DEPTH=3, 3 beats in flight with in_valid=1 and flush=1: next cycle out_valid=0, and the presented beat is never emitted.
- Reset mid-stream: drop rst_n between edges; out_valid and imm read 0 immediately. After release, in_ready=1 and the first new beat emerges with correct latency.
- Random traffic: random valid/ready for 10k beats against a reference model; order, values and err flags match.
